// File: rtl/ex_stage.sv
// ex_stage: execute-stage controller wrapped around a 32-bit combinational ALU.
// Accepts ops from decode (valid/ready), holds the ALU operands stable for a
// per-op window (MUL_LAT / DIV_LAT cycles for MUL / DIV, one cycle otherwise),
// then registers the result for memory/writeback (valid/ready).
// A divide by zero skips the DIV window and yields all-ones with out_dz set.
// Optional build macro: EX_TRACE_EN prints a line per result capture.
module ex_stage #(
  parameter int MUL_LAT = 4,  // legal 1..16
  parameter int DIV_LAT = 8   // legal 1..16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_sel,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_r,
  input  logic        alu_zf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic        out_zf,
  output logic [4:0]  out_rd,
  output logic        out_dz,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  localparam logic [2:0] SEL_MUL = 3'd5;
  localparam logic [2:0] SEL_DIV = 3'd6;
  // Counter preloads hold L-1 so the capture happens on the L-th edge.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_sel;
  logic [4:0]  r_rd;
  logic        r_dz;
  logic        r_out_valid;
  logic [31:0] r_out_r;
  logic        r_out_zf;
  logic [4:0]  r_out_rd;
  logic        r_out_dz;

  logic        w_accept;
  logic        w_done;
  logic        w_dz_in;
  logic [3:0]  w_cnt_load;

  // Ready depends only on state and the output slot, never on in_valid,
  // so upstream can't form a combinational loop through us.
  assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_done   = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_dz_in  = (in_sel == SEL_DIV) && (in_b == 32'd0);

  // Hold-window length for the incoming op; a zero divisor collapses DIV to one cycle.
  always_comb begin
    // NOTE: default first so every path assigns w_cnt_load and no latch is inferred.
    w_cnt_load = 4'd0;
    if (in_sel == SEL_MUL)                 w_cnt_load = MUL_CNT;
    else if (in_sel == SEL_DIV && !w_dz_in) w_cnt_load = DIV_CNT;
  end

  // Control FSM: latch the op on accept, count down the hold window, return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_sel   <= 3'd0;
      r_rd    <= 5'd0;
      r_dz    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_sel   <= in_sel;
            r_rd    <= in_rd;
            r_dz    <= w_dz_in;
            r_cnt   <= w_cnt_load;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else               r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result register: load on completion, otherwise drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_r     <= 32'd0;
      r_out_zf    <= 1'b0;
      r_out_rd    <= 5'd0;
      r_out_dz    <= 1'b0;
    end else if (w_done) begin
      r_out_valid <= 1'b1;
      r_out_r     <= r_dz ? 32'hFFFF_FFFF : alu_r;
      r_out_zf    <= r_dz ? 1'b0 : (alu_r == 32'd0);
      r_out_rd    <= r_rd;
      r_out_dz    <= r_dz;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign busy      = (r_state == S_EXEC);
  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_zf    = r_out_zf;
  assign out_rd    = r_out_rd;
  assign out_dz    = r_out_dz;

`ifdef EX_TRACE_EN
  // Trace every capture and flag an ALU whose zero flag disagrees with its result.
  always_ff @(posedge clk) begin
    if (rst_n && w_done) begin
      $display("%0t ex_stage: sel=%0d a=%08h b=%08h r=%08h rd=%0d dz=%0b",
               $time, r_sel, r_a, r_b, r_dz ? 32'hFFFF_FFFF : alu_r, r_rd, r_dz);
      if (!r_dz && (alu_zf != (alu_r == 32'd0)))
        $display("%0t ex_stage: warning alu_zf=%0b disagrees with alu_r=%08h",
                 $time, alu_zf, alu_r);
    end
  end
`else
  // The ALU zero flag only feeds the trace; out_zf is derived from the result.
  logic w_unused_zf;
  assign w_unused_zf = alu_zf;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed plus randomized checks of ex_stage against a
// behavioural model (ALU arithmetic, expected capture value, expected latency).
module tb_ex_stage;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_sel = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_r;
  logic        alu_zf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_r;
  logic        out_zf;
  logic [4:0]  out_rd;
  logic        out_dz;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  ex_stage #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_r(alu_r), .alu_zf(alu_zf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_zf(out_zf), .out_rd(out_rd), .out_dz(out_dz),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; divide by zero returns 0 so an unmasked capture is visible.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] sel);
    case (sel)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (a < b) ? 32'd1 : 32'd0;
      3'd5: return a * b;
      3'd6: return (b == 32'd0) ? 32'd0 : a / b;
      default: return b;
    endcase
  endfunction

  always_comb begin
    alu_r  = alu_model(alu_a, alu_b, alu_sel);
    alu_zf = (alu_r == 32'd0);
  end

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] sel);
    if (sel == 3'd6 && b == 32'd0) return 32'hFFFF_FFFF;
    return alu_model(a, b, sel);
  endfunction

  function automatic int exp_lat(input logic [31:0] b, input logic [2:0] sel);
    if (sel == 3'd5) return MUL_LAT;
    if (sel == 3'd6) return (b == 32'd0) ? 1 : DIV_LAT;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Issue one op, verify the hold window, latency and captured result, then
  // optionally stall the consumer for 'stall' cycles checking the result holds.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                        input logic [4:0] rd, input int stall);
    int n;
    bit hold_ok, busy_ok, rdy_ok, keep_ok;
    logic [31:0] er;
    er = exp_result(a, b, sel);
    @(negedge clk);
    in_a = a; in_b = b; in_sel = sel; in_rd = rd; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_before_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0; hold_ok = 1; busy_ok = 1; rdy_ok = 1;
    while (!out_valid && n < 40) begin
      if (alu_a !== a || alu_b !== b || alu_sel !== sel) hold_ok = 0;
      if (busy !== 1'b1) busy_ok = 0;
      if (in_ready !== 1'b0) rdy_ok = 0;
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat(b, sel));
    check("alu_hold", hold_ok, 1'b1);
    check("busy_window", busy_ok, 1'b1);
    check("in_ready_low_exec", rdy_ok, 1'b1);
    check("out_r", out_r, er);
    check("out_zf", out_zf, (sel == 3'd6 && b == 32'd0) ? 1'b0 : (er == 32'd0));
    check("out_rd", out_rd, rd);
    check("out_dz", out_dz, (sel == 3'd6 && b == 32'd0));
    check("busy_after", busy, 1'b0);
    check("alu_kept_idle", (alu_a == a && alu_b == b && alu_sel == sel), 1'b1);
    if (stall > 0) begin
      out_ready = 1'b0;
      keep_ok = 1;
      repeat (stall) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_r !== er || out_rd !== rd || in_ready !== 1'b0)
          keep_ok = 0;
      end
      check("stall_hold", keep_ok, 1'b1);
      out_ready = 1'b1;
    end
  endtask

  initial begin
    int acc;
    bit ok;
    logic [31:0] a, b;
    logic [2:0] sel;

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_outs", {out_r, 27'd0, out_rd} | {alu_a} | {alu_b}, 64'd0);
    check("rst_flags", {out_zf, out_dz, alu_sel}, 5'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    // Directed ops from the plan
    run_op(32'd5, 32'd7, 3'd0, 5'd3, 0);
    run_op(32'd9, 32'd9, 3'd1, 5'd4, 0);
    run_op(32'd6, 32'd7, 3'd5, 5'd5, 0);
    run_op(32'd100, 32'd0, 3'd6, 5'd6, 0);
    run_op(32'd100, 32'd7, 3'd6, 5'd7, 0);
    run_op(32'd3, 32'd9, 3'd4, 5'd8, 0);

    // Back-to-back single-cycle ops: one accept every two cycles
    @(negedge clk);
    in_a = 32'd1; in_b = 32'd2; in_sel = 3'd0; in_rd = 5'd9; in_valid = 1'b1;
    acc = 0;
    repeat (10) begin
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc, 5);
    repeat (3) @(negedge clk);

    // Backpressure: result held, second op stalls, then consume+accept together
    out_ready = 1'b0;
    run_op(32'd3, 32'd4, 3'd0, 5'd1, 0);
    in_a = 32'hF0; in_b = 32'h0F; in_sel = 3'd3; in_rd = 5'd2; in_valid = 1'b1;
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_r !== 32'd7 || busy !== 1'b0) ok = 0;
    end
    check("bp_hold", ok, 1'b1);
    out_ready = 1'b1;
    #1 check("bp_ready_comb", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_consumed", out_valid, 1'b0);
    check("bp_second_busy", busy, 1'b1);
    check("bp_second_alu_a", alu_a, 32'hF0);
    @(negedge clk);
    check("bp_second_valid", out_valid, 1'b1);
    check("bp_second_r", out_r, 32'hFF);
    check("bp_second_rd", out_rd, 5'd2);
    repeat (2) @(negedge clk);

    // Reset in the middle of a DIV window
    in_a = 32'd100; in_b = 32'd7; in_sel = 3'd6; in_rd = 5'd11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_zero", (alu_a | alu_b | out_r | {27'd0, out_rd} | {29'd0, alu_sel}), 32'd0);
    check("mid_rst_flags", {out_zf, out_dz}, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 0;
    end
    check("no_emit_after_rst", ok, 1'b1);

    // Randomized ops with random consumer stalls
    for (int i = 0; i < 60; i++) begin
      sel = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(a, b, sel, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute-stage controller directly upstream and downstream of the 32-bit combinational ALU.
- Takes operations from decode over a valid/ready handshake and drives the ALU operands and select, holding them stable.
- Holds the inputs for a multicycle window on MUL and DIV, then captures the result into an output register that feeds memory/writeback over a second valid/ready handshake.
- Uses the ALU select encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL, 6 DIV, 7 PASS-B.

Parameters:
- MUL_LAT, 4: cycles the ALU inputs are held for SEL=5; legal 1..16.
- DIV_LAT, 8: cycles the ALU inputs are held for SEL=6; legal 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept an op
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_sel  in  3  ALU op code
- in_rd  in  5  destination register tag, passed through
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_sel  out  3  to ALU SEL
- alu_r  in  32  from ALU R
- alu_zf  in  1  from ALU ZF; used only under EX_TRACE_EN
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_r  out  32  result
- out_zf  out  1  result == 0
- out_rd  out  5  destination tag
- out_dz  out  1  divide-by-zero flag
- busy  out  1  high while in EXEC

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - All of alu_a, alu_b, alu_sel, out_r, out_rd = 0.
  - out_valid, out_zf, out_dz, busy = 0.
  - Reset mid-operation abandons the op; nothing is emitted after release.
- FSM with states IDLE and EXEC.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational and never depends on in_valid.
- Accept:
  - An op is accepted when in_valid && in_ready at a rising edge.
  - On accept: latch in_a, in_b, in_sel, in_rd into operand registers; go to EXEC.
  - Counter loads L-1, where L = MUL_LAT for sel 5, DIV_LAT for sel 6, else 1.
  - Exception: DIV with in_b==0 forces L=1.
- alu_a, alu_b, alu_sel are driven straight from the operand registers. They are constant for the whole EXEC window and keep the last op's values in IDLE (no toggling).
- EXEC:
  - busy=1.
  - If counter != 0: decrement.
  - If counter == 0, at the edge: out_r <= alu_r, out_zf <= (alu_r==32'd0), out_rd <= tag, out_dz <= 0, out_valid <= 1; go to IDLE.
- Divide by zero (sel 6, B==0): the ALU result is ignored. Capture out_r=32'hFFFF_FFFF, out_zf=0, out_dz=1.
- Latency:
  - An op accepted at edge k has out_valid high after edge k+L.
  - Peak throughput is one op per L+1 cycles. in_ready is low for the whole EXEC window.
- Output register:
  - out_valid stays high, and out_r, out_zf, out_rd, out_dz stay stable, until out_valid && out_ready at an edge.
  - If a new op completes on the same edge the old result is consumed, the new result loads and out_valid stays 1.
  - If the result is consumed with no completion, out_valid <= 0; the data registers keep their values.
- Simultaneous events: consume and accept on the same edge is legal (in_ready already includes out_ready). in_valid while not ready is ignored and the upstream must hold its op.
- Width rules:
  - No width extension: all results are 32 bits, carries are discarded.
  - out_zf is derived from the captured result, never from alu_zf.
  - SLT is unsigned compare (ALU behaviour).

Optional Feature:
- Macro EX_TRACE_EN.
- When defined: at every result capture, the stage prints simulation time, op code, A, B, result, rd and dz. It also prints a mismatch warning if alu_zf != (alu_r==0) on a non-DZ capture.
- When undefined: no display statements and alu_zf is unused. Cycle behaviour is identical in both builds.

Test Plan:
- ADD, A=5 B=7 rd=3, out_ready=1:
  - Accept at edge k; out_valid after k+1 with out_r=12, out_zf=0, out_rd=3.
  - in_ready low during cycle k..k+1.
- SUB, A=9 B=9:
  - out_r=0, out_zf=1.
  - Back-to-back ops with out_ready=1 are accepted every 2 cycles.
- MUL 6*7, MUL_LAT=4:
  - alu_a/alu_b/alu_sel stable for 4 cycles, busy=1 for 4 cycles.
  - out_r=42 after edge k+4.
- DIV, A=100 B=0:
  - Result after k+1 (not DIV_LAT): out_r=32'hFFFFFFFF, out_dz=1, out_zf=0.
  - Next DIV, 100/7 with DIV_LAT=8: out_r=14, out_dz=0 after k+8.
- Backpressure, out_ready=0 after first result:
  - out_valid holds with stable data; in_ready=0; second op stalls.
  - Raise out_ready: consumed, second op accepted on same edge.
- Assert rst_n=0 mid-DIV:
  - All outputs 0 immediately (async).
  - No out_valid after release until a new op is accepted.
